uart_rx: RTL and testbench

// - Serial UART receiver; counterpart of the TX_Top transmit path. Recovers 11-bit frames
//   (start, 8 data LSB-first, parity, stop) from the serial line and checks parity and stop.
// - Sits between the board RX pin and the consumer logic. Uses the same baud_rate and

---
 rtl/uart_rx.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 11-bit frames (start, 8 data LSB-first, parity, stop) with parity/stop checks.
// Optional build macro RX_GLITCH_FILTER_EN enables 2-of-3 majority sampling of each bit.
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       data_rx,
    output logic [7:0] data_out,
    output logic       parity_error,
    output logic       stop_error,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int DIV_MAX = CLK_FREQ / (2400 * OVERSAMPLE) - 1;
    localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX + 1) : 1;
    localparam int TICK_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_2400  = DIV_W'(CLK_FREQ / (2400 * OVERSAMPLE) - 1);
    localparam logic [DIV_W-1:0] DIV_4800  = DIV_W'(CLK_FREQ / (4800 * OVERSAMPLE) - 1);
    localparam logic [DIV_W-1:0] DIV_9600  = DIV_W'(CLK_FREQ / (9600 * OVERSAMPLE) - 1);
    localparam logic [DIV_W-1:0] DIV_19200 = DIV_W'(CLK_FREQ / (19200 * OVERSAMPLE) - 1);

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state_q, state_d;

    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic              rx_sample;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]  divisor;
    logic              tick;
    logic              div_clr;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [1:0]        baud_q, baud_d;
    logic [1:0]        par_type_q, par_type_d;
    logic              par_err_q, par_err_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              perr_out_q, perr_out_d;
    logic              serr_out_q, serr_out_d;
    logic              active_q, active_d;
    logic              done_q, done_d;

    // Two-flop synchronizer plus one delayed copy used for falling-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= data_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

`ifdef RX_GLITCH_FILTER_EN
    logic rx_old_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_old_q <= 1'b1;
        end else begin
            rx_old_q <= rx_prev_q;
        end
    end

    // Majority of three consecutive synced clocks; a one-clock glitch cannot win.
    assign rx_sample = (rx_sync_q & rx_prev_q) | (rx_sync_q & rx_old_q) | (rx_prev_q & rx_old_q);
`else
    assign rx_sample = rx_sync_q;
`endif

    always_comb begin
        divisor = DIV_2400;
        case (baud_q)
            2'b00:   divisor = DIV_2400;
            2'b01:   divisor = DIV_4800;
            2'b10:   divisor = DIV_9600;
            default: divisor = DIV_19200;
        endcase
    end

    assign tick = (div_cnt_q == divisor);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        baud_d     = baud_q;
        par_type_d = par_type_q;
        par_err_d  = par_err_q;
        data_out_d = data_out_q;
        perr_out_d = perr_out_q;
        serr_out_d = serr_out_q;
        active_d   = active_q;
        done_d     = 1'b0;
        div_clr    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d    = S_START;
                    active_d   = 1'b1;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    baud_d     = baud_rate;
                    par_type_d = parity_type;
                    div_clr    = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_HALF) begin
                        tick_cnt_d = '0;
                        if (rx_sample) begin
                            state_d  = S_IDLE;
                            active_d = 1'b0;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_sample, shift_q[7:1]};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = S_STOP;
                        case (par_type_q)
                            2'b01:   par_err_d = ~^{shift_q, rx_sample};
                            2'b10:   par_err_d = ^{shift_q, rx_sample};
                            default: par_err_d = 1'b0;
                        endcase
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        data_out_d = shift_q;
                        perr_out_d = par_err_q;
                        serr_out_d = ~rx_sample;
                        done_d     = 1'b1;
                        active_d   = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                active_d = 1'b0;
            end
        endcase

        // Clearing on START entry phase-aligns the tick grid to the detected edge.
        if (div_clr || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            baud_q     <= '0;
            par_type_q <= '0;
            par_err_q  <= 1'b0;
            data_out_q <= '0;
            perr_out_q <= 1'b0;
            serr_out_q <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            baud_q     <= baud_d;
            par_type_q <= par_type_d;
            par_err_q  <= par_err_d;
            data_out_q <= data_out_d;
            perr_out_q <= perr_out_d;
            serr_out_q <= serr_out_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign data_out     = data_out_q;
    assign parity_error = perr_out_q;
    assign stop_error   = serr_out_q;
    assign active_flag  = active_q;
    assign done_flag    = done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit and checked through an expected-result queue.
module tb_uart_rx;

    localparam int CLK_FREQ   = 307_200;
    localparam int OVERSAMPLE = 16;
    localparam int CPB_2400   = 128;
    localparam int CPB_4800   = 64;
    localparam int CPB_9600   = 32;
    localparam int CPB_19200  = 16;

    logic       clock;
    logic       reset_n;
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic       data_rx;
    logic [7:0] data_out;
    logic       parity_error;
    logic       stop_error;
    logic       active_flag;
    logic       done_flag;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int active_rise_cnt = 0;
    logic done_prev = 1'b0;
    logic active_prev = 1'b0;

    // Each entry is {data, parity_error, stop_error}.
    logic [9:0] exp_q[$];

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .baud_rate   (baud_rate),
        .parity_type (parity_type),
        .data_rx     (data_rx),
        .data_out    (data_out),
        .parity_error(parity_error),
        .stop_error  (stop_error),
        .active_flag (active_flag),
        .done_flag   (done_flag)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_perr(input logic [1:0] ptype, input logic [7:0] d, input logic p);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) ones++;
        end
        if (p) ones++;
        if (ptype == 2'b01) return (ones % 2) == 0;
        if (ptype == 2'b10) return (ones % 2) == 1;
        return 1'b0;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int cpb);
        data_rx = 1'b0;
        idle(cpb);
        for (int i = 0; i < 8; i++) begin
            data_rx = d[i];
            idle(cpb);
        end
        data_rx = p;
        idle(cpb);
        data_rx = s;
        idle(cpb);
        data_rx = 1'b1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p, input logic s);
        exp_q.push_back({d, exp_perr(parity_type, d, p), ~s});
    endtask

    // Output monitor: every done pulse pops one expected frame result.
    always @(negedge clock) begin
        if (done_flag) begin
            done_cnt++;
            tests++;
            assert (done_prev === 1'b0) else begin
                fails++;
                $error("FAIL done_width: observed done high on consecutive clocks expected 1 clock");
            end
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_done: observed done with data %0h expected no frame", data_out);
            end
            if (exp_q.size() > 0) begin
                logic [9:0] e;
                e = exp_q.pop_front();
                tests++;
                assert ({data_out, parity_error, stop_error} === e) else begin
                    fails++;
                    $error("FAIL frame_result: observed data=%0h perr=%0b serr=%0b expected data=%0h perr=%0b serr=%0b",
                           data_out, parity_error, stop_error, e[9:2], e[1], e[0]);
                end
            end
        end
        if (active_flag && !active_prev) active_rise_cnt++;
        done_prev   = done_flag;
        active_prev = active_flag;
    end

    initial begin
        int d0;
        int a0;
        reset_n     = 1'b0;
        baud_rate   = 2'b10;
        parity_type = 2'b00;
        data_rx     = 1'b1;
        idle(4);
        check("rst_data_out", {24'd0, data_out}, 32'h0);
        check("rst_parity_error", {31'd0, parity_error}, 32'd0);
        check("rst_stop_error", {31'd0, stop_error}, 32'd0);
        check("rst_active", {31'd0, active_flag}, 32'd0);
        check("rst_done", {31'd0, done_flag}, 32'd0);
        reset_n = 1'b1;
        idle(8);

        // 0xA5, even parity, correct parity bit, 9600 baud.
        baud_rate = 2'b10; parity_type = 2'b10;
        d0 = done_cnt;
        push_exp(8'hA5, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1, CPB_9600);
        idle(8);
        check("a5_done_count", done_cnt - d0, 32'd1);
        check("a5_held", {24'd0, data_out}, 32'hA5);
        check("a5_active_low", {31'd0, active_flag}, 32'd0);

        // 0x3C, odd parity, wrong parity bit, 4800 baud; then the correct bit.
        baud_rate = 2'b01; parity_type = 2'b01;
        d0 = done_cnt;
        push_exp(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, CPB_4800);
        idle(8);
        check("3c_bad_parity_flag", {31'd0, parity_error}, 32'd1);
        push_exp(8'h3C, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1, CPB_4800);
        idle(8);
        check("3c_done_count", done_cnt - d0, 32'd2);
        check("3c_good_parity_flag", {31'd0, parity_error}, 32'd0);

        // 0x55 with a low stop bit, line then held low for three bit times.
        baud_rate = 2'b10; parity_type = 2'b00;
        d0 = done_cnt;
        push_exp(8'h55, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0, CPB_9600);
        data_rx = 1'b0;
        idle(3 * CPB_9600);
        check("break_active_low", {31'd0, active_flag}, 32'd0);
        data_rx = 1'b1;
        idle(2 * CPB_9600);
        check("break_done_count", done_cnt - d0, 32'd1);
        check("break_stop_error", {31'd0, stop_error}, 32'd1);

        // Quarter-bit low pulse on an idle line is a false start.
        d0 = done_cnt;
        a0 = active_rise_cnt;
        data_rx = 1'b0;
        idle(CPB_9600 / 4);
        data_rx = 1'b1;
        idle(2 * CPB_9600);
        check("glitch_active_pulse", active_rise_cnt - a0, 32'd1);
        check("glitch_no_done", done_cnt - d0, 32'd0);
        check("glitch_data_kept", {24'd0, data_out}, 32'h55);
        check("glitch_active_low", {31'd0, active_flag}, 32'd0);

        // Back-to-back frames at 19200, parity none.
        baud_rate = 2'b11; parity_type = 2'b11;
        d0 = done_cnt;
        push_exp(8'h01, 1'b0, 1'b1);
        push_exp(8'hFE, 1'b1, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1, CPB_19200);
        send_frame(8'hFE, 1'b1, 1'b1, CPB_19200);
        idle(8);
        check("b2b_done_count", done_cnt - d0, 32'd2);
        check("b2b_last_data", {24'd0, data_out}, 32'hFE);

        // Reset in the middle of data bit 4, then a clean 0x81 at 2400 baud.
        baud_rate = 2'b10; parity_type = 2'b10;
        d0 = done_cnt;
        data_rx = 1'b0;
        idle(CPB_9600 * 5 + CPB_9600 / 2);
        check("abort_active_before", {31'd0, active_flag}, 32'd1);
        reset_n = 1'b0;
        idle(2);
        check("abort_data_cleared", {24'd0, data_out}, 32'h0);
        check("abort_active_cleared", {31'd0, active_flag}, 32'd0);
        data_rx = 1'b1;
        idle(2);
        reset_n = 1'b1;
        idle(4 * CPB_9600);
        check("abort_no_done", done_cnt - d0, 32'd0);
        baud_rate = 2'b00;
        push_exp(8'h81, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b1, CPB_2400);
        idle(8);
        check("after_abort_done_count", done_cnt - d0, 32'd1);
        check("after_abort_data", {24'd0, data_out}, 32'h81);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
